// File: rtl/ddr3_pixel_unpack.sv
// Unpacks 128-bit DDR3 read words (four 32-bit pixels) into one 24-bit RGB pixel per request, 1-cycle latency.
// Two-word prefetch buffer; FIFO pops only while buffer plus in-flight read holds fewer than two words.
module ddr3_pixel_unpack #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic [127:0] fifo_rd_data,
    input  logic         frame_start,
    input  logic         pix_req,
    output logic         pix_valid,
    output logic [23:0]  pix_rgb,
    output logic         underflow,
    output logic         frame_err,
    input  logic         err_clr,
    output logic [23:0]  pixel_count
);

    localparam int          FRAME_PIXELS   = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [23:0] FRAME_PIXELS_W = 24'(FRAME_PIXELS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]   state;
    logic [127:0] slot0;
    logic [127:0] slot1;
    logic [1:0]   occ;
    logic         inflight;
    logic [1:0]   idx;

    logic         run;
    logic         consume;
    logic         release_head;
    logic [1:0]   occ_after_rel;
    logic [23:0]  head_pix;

    // Only registered occupancy counts as available, so a word landing this cycle cannot serve a request.
    assign run           = (state == ST_RUN);
    assign consume       = run && pix_req && (occ != 2'd0);
    assign release_head  = consume && (idx == 2'd3);
    assign occ_after_rel = occ - {1'b0, release_head};
    assign head_pix      = slot0[{idx, 5'd0} +: 24];

    assign fifo_rd_en = !reset && !fifo_empty && (({1'b0, occ} + {2'b00, inflight}) < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            slot0       <= '0;
            slot1       <= '0;
            occ         <= 2'd0;
            inflight    <= 1'b0;
            idx         <= 2'd0;
            pix_valid   <= 1'b0;
            pix_rgb     <= 24'd0;
            underflow   <= 1'b0;
            frame_err   <= 1'b0;
            pixel_count <= 24'd0;
        end else begin
            inflight  <= fifo_rd_en;
            pix_valid <= pix_req;

            if (pix_req) begin
                pix_rgb <= consume ? head_pix : 24'd0;
            end
            if (consume) begin
                idx <= idx + 2'd1;
            end

            // Head release shifts the queue; an arriving word lands in whichever slot is the tail afterwards.
            if (release_head) begin
                slot0 <= slot1;
            end
            if (inflight) begin
                if (occ_after_rel == 2'd0) begin
                    slot0 <= fifo_rd_data;
                end else begin
                    slot1 <= fifo_rd_data;
                end
            end
            occ <= occ_after_rel + {1'b0, inflight};

            if (frame_start) begin
                state <= ST_RUN;
            end

            if (run && pix_req && (occ == 2'd0)) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end

            if (frame_start && run && (pixel_count != FRAME_PIXELS_W)) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end

            // A request coinciding with frame_start is the first pixel of the new frame.
            if (frame_start) begin
                pixel_count <= (run && pix_req) ? 24'd1 : 24'd0;
            end else if (run && pix_req && (pixel_count != 24'hFF_FFFF)) begin
                pixel_count <= pixel_count + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_pixel_unpack.sv
// Randomized bench for ddr3_pixel_unpack against a pixel-queue reference model.
module tb_ddr3_pixel_unpack;

    localparam int FP = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [127:0] fifo_rd_data;
    logic         frame_start;
    logic         pix_req;
    logic         pix_valid;
    logic [23:0]  pix_rgb;
    logic         underflow;
    logic         frame_err;
    logic         err_clr;
    logic [23:0]  pixel_count;

    ddr3_pixel_unpack #(.IMAGE_WIDTH(8), .IMAGE_HEIGHT(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .frame_start  (frame_start),
        .pix_req      (pix_req),
        .pix_valid    (pix_valid),
        .pix_rgb      (pix_rgb),
        .underflow    (underflow),
        .frame_err    (frame_err),
        .err_clr      (err_clr),
        .pixel_count  (pixel_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] px;
        int          rdy;
    } pix_t;

    logic [127:0] fifo_q[$];
    pix_t         pixq[$];

    int          total = 0;
    int          bad = 0;
    int          edge_n = 0;
    int          rd_pulses = 0;
    logic        rd_s;

    logic        m_run;
    logic        m_valid;
    logic [23:0] m_rgb;
    logic        m_uf;
    logic        m_fe;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic push_word(input logic [127:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic refill();
        while (fifo_q.size() < 3) begin
            push_word({$urandom, $urandom, $urandom, $urandom});
        end
    endtask

    // Reference: pixels become servable two edges after their word is popped from the FIFO.
    task automatic model_step();
        logic uf_set;
        logic fe_set;
        pix_t p;
        if (reset) begin
            m_run = 1'b0;
            pixq.delete();
            m_valid = 1'b0;
            m_rgb = 24'd0;
            m_uf = 1'b0;
            m_fe = 1'b0;
            m_cnt = 0;
        end else begin
            uf_set = 1'b0;
            fe_set = 1'b0;
            m_valid = pix_req;
            if (pix_req) begin
                m_rgb = 24'd0;
                if (m_run) begin
                    if (pixq.size() > 0 && pixq[0].rdy <= edge_n) begin
                        p = pixq.pop_front();
                        m_rgb = p.px;
                    end else begin
                        uf_set = 1'b1;
                    end
                end
            end
            if (frame_start) begin
                if (m_run && m_cnt != FP) fe_set = 1'b1;
                m_cnt = (m_run && pix_req) ? 1 : 0;
                m_run = 1'b1;
            end else if (m_run && pix_req && m_cnt < 24'hFF_FFFF) begin
                m_cnt++;
            end
            if (uf_set) m_uf = 1'b1;
            else if (err_clr) m_uf = 1'b0;
            if (fe_set) m_fe = 1'b1;
            else if (err_clr) m_fe = 1'b0;
        end
    endtask

    task automatic cyc();
        logic exp_rd;
        logic [127:0] w;
        pix_t p;
        #1;
        exp_rd = !reset && !fifo_empty && (((pixq.size() + 3) / 4) < 2);
        chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        rd_s = fifo_rd_en;
        @(posedge clk);
        edge_n++;
        model_step();
        #1;
        chk("pix_valid", 32'(pix_valid), 32'(m_valid));
        chk("pix_rgb", 32'(pix_rgb), 32'(m_rgb));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
        chk("pixel_count", 32'(pixel_count), 32'(m_cnt));
        if (rd_s && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            fifo_rd_data = w;
            rd_pulses++;
            for (int k = 0; k < 4; k++) begin
                p.px = w[32*k +: 24];
                p.rdy = edge_n + 2;
                pixq.push_back(p);
            end
        end
        fifo_empty = (fifo_q.size() == 0);
        #1;
    endtask

    task automatic drive(input logic req, input logic fs, input logic clr);
        pix_req = req;
        frame_start = fs;
        err_clr = clr;
        cyc();
    endtask

    initial begin
        int carry;
        int n;
        int guard;
        reset = 1'b1;
        fifo_empty = 1'b1;
        fifo_rd_data = '0;
        pix_req = 1'b0;
        frame_start = 1'b0;
        err_clr = 1'b0;
        rd_s = 1'b0;

        repeat (3) drive(0, 0, 0);
        drive(1, 0, 0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_cnt", 32'(pixel_count), 32'd0);

        // Three words ready at reset release: only two may be fetched.
        push_word({32'hAB00_0004, 32'hCD00_0003, 32'hEF00_0002, 32'h1200_0001});
        push_word({$urandom, $urandom, $urandom, $urandom});
        push_word({$urandom, $urandom, $urandom, $urandom});
        rd_pulses = 0;
        reset = 1'b0;
        repeat (8) drive(0, 0, 0);
        chk("t1_rd_pulses", 32'(rd_pulses), 32'd2);
        chk("t1_fifo_left", 32'(fifo_q.size()), 32'd1);

        drive(0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0);
            chk("t2_pix", 32'(pix_rgb), 32'(i));
            chk("t2_valid", 32'(pix_valid), 32'd1);
        end
        drive(0, 0, 0);
        chk("t2_valid_drop", 32'(pix_valid), 32'd0);
        chk("t2_rgb_hold", 32'(pix_rgb), 32'd4);

        // Drain the remaining two words, then starve.
        repeat (3) drive(0, 0, 0);
        repeat (8) drive(1, 0, 0);
        drive(1, 0, 0);
        chk("t3_uf_set", 32'(underflow), 32'd1);
        chk("t3_rgb_black", 32'(pix_rgb), 32'd0);
        repeat (2) drive(0, 0, 0);
        chk("t3_uf_sticky", 32'(underflow), 32'd1);
        drive(1, 0, 1);
        chk("t3_uf_set_wins", 32'(underflow), 32'd1);
        drive(0, 0, 1);
        chk("t3_uf_clr", 32'(underflow), 32'd0);

        drive(0, 1, 0);
        chk("t4_fe_first", 32'(frame_err), 32'd1);
        drive(0, 0, 1);
        chk("t4_fe_clr", 32'(frame_err), 32'd0);
        repeat (4) push_word({$urandom, $urandom, $urandom, $urandom});
        repeat (4) drive(0, 0, 0);
        drive(0, 1, 0);
        repeat (15) drive(1, 0, 0);
        drive(0, 1, 0);
        chk("t4_fe_short", 32'(frame_err), 32'd1);
        chk("t4_cnt_zero", 32'(pixel_count), 32'd0);

        // Three well-formed frames with random request gaps and continuous refill.
        reset = 1'b1;
        drive(0, 0, 0);
        reset = 1'b0;
        repeat (4) begin refill(); drive(0, 0, 0); end
        drive(0, 1, 0);
        carry = 0;
        for (int f = 0; f < 3; f++) begin
            n = carry;
            guard = 0;
            while (n < FP && guard < 200) begin
                refill();
                guard++;
                if ($urandom_range(0, 3) != 0) begin
                    drive(1, 0, 0);
                    n++;
                end else begin
                    drive(0, 0, 0);
                end
            end
            chk("t5_frame_budget", 32'(n), 32'(FP));
            refill();
            carry = (f == 0) ? 1 : 0;
            drive(carry[0], 1, 0);
            chk("t5_cnt_after_fs", 32'(pixel_count), 32'(carry));
        end
        chk("t5_fe", 32'(frame_err), 32'd0);
        chk("t5_uf", 32'(underflow), 32'd0);

        // Reset mid-frame with the buffer full.
        refill();
        repeat (4) drive(0, 0, 0);
        drive(1, 0, 0);
        reset = 1'b1;
        drive(1, 0, 0);
        reset = 1'b0;
        chk("t6_valid", 32'(pix_valid), 32'd0);
        chk("t6_rgb", 32'(pix_rgb), 32'd0);
        chk("t6_cnt", 32'(pixel_count), 32'd0);
        repeat (3) drive(1, 0, 0);
        chk("t6_idle_valid", 32'(pix_valid), 32'd1);
        chk("t6_idle_rgb", 32'(pix_rgb), 32'd0);
        chk("t6_idle_uf", 32'(underflow), 32'd0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) refill();
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 4) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
